// File: rtl/craft_tweakey_sequencer.sv
// CRAFT round-tweakey sequencer: latches key/tweak on start and streams TK_r in ascending or descending order.
// Optional CRAFT_TK_MIXCOL_EN applies the MixColumn (equivalent-decryption tweakey) before the tk register.
module craft_tweakey_sequencer #(
    parameter int ROUNDS = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         dir,
    input  logic [127:0] key,
    input  logic [63:0]  tweak,
    output logic [63:0]  tk,
    output logic [7:0]   tk_round,
    output logic         tk_valid,
    input  logic         tk_ready,
    output logic         tk_last,
    output logic         busy,
    output logic         done
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);
    localparam logic [3:0] Q_PERM [16] = '{4'd12, 4'd10, 4'd15, 4'd5, 4'd14, 4'd8, 4'd9, 4'd2,
                                           4'd11, 4'd3,  4'd7,  4'd4, 4'd6,  4'd0, 4'd1, 4'd13};

    // Nibble 0 is the most significant nibble.
    function automatic logic [63:0] q_permute(input logic [63:0] t);
        logic [63:0] p;
        p = '0;
        for (int k = 0; k < 16; k++)
            p[63-4*k -: 4] = t[63-4*int'(Q_PERM[k]) -: 4];
        return p;
    endfunction

`ifdef CRAFT_TK_MIXCOL_EN
    function automatic logic [63:0] mix_column(input logic [63:0] x);
        logic [15:0] r0, r1, r2, r3;
        {r0, r1, r2, r3} = x;
        return {r0 ^ r2 ^ r3, r1 ^ r3, r2, r3};
    endfunction
`endif

    state_t      state, state_next;
    logic        capture, step, finish;

    logic [63:0] k0_q, k1_q, t_q, qt_q;
    logic        dir_q;

    logic        dir_sel;
    logic [7:0]  round_next;
    logic        last_next;
    logic [63:0] src_k, src_t, tk_raw, tk_next;

    // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (tk_ready) begin
                    if (tk_last) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // On capture the tweakey is built straight from the ports so the first tk lands on the same edge.
    always_comb begin
        dir_sel = capture ? dir : dir_q;
        if (capture)
            round_next = dir ? LAST_ROUND : 8'd0;
        else
            round_next = dir_q ? tk_round - 8'd1 : tk_round + 8'd1;
        last_next = dir_sel ? (round_next == 8'd0) : (round_next == LAST_ROUND);

        if (round_next[0]) src_k = capture ? key[63:0]   : k1_q;
        else               src_k = capture ? key[127:64] : k0_q;
        if (round_next[1]) src_t = capture ? q_permute(tweak) : qt_q;
        else               src_t = capture ? tweak            : t_q;

        tk_raw = src_k ^ src_t;
`ifdef CRAFT_TK_MIXCOL_EN
        tk_next = mix_column(tk_raw);
`else
        tk_next = tk_raw;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k0_q     <= '0;
            k1_q     <= '0;
            t_q      <= '0;
            qt_q     <= '0;
            dir_q    <= 1'b0;
            tk       <= '0;
            tk_round <= '0;
            tk_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (capture) begin
                k0_q  <= key[127:64];
                k1_q  <= key[63:0];
                t_q   <= tweak;
                qt_q  <= q_permute(tweak);
                dir_q <= dir;
            end
            if (capture || step) begin
                tk       <= tk_next;
                tk_round <= round_next;
                tk_last  <= last_next;
            end
            done <= finish;
        end
    end

    assign tk_valid = (state == STREAM);
    assign busy     = (state == STREAM);

endmodule

// File: tb/tb_craft_tweakey_sequencer.sv
// Self-checking bench for craft_tweakey_sequencer: directed vectors plus randomized runs
// compared every cycle against a nibble-level model of the CRAFT tweakey schedule.
module tb_craft_tweakey_sequencer;

    localparam int ROUNDS = 32;
    localparam logic [127:0] KEY = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [63:0]  TW  = 64'h0123456789ABCDEF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         dir = 1'b0;
    logic [127:0] key = KEY;
    logic [63:0]  tweak = TW;
    logic [63:0]  tk;
    logic [7:0]   tk_round;
    logic         tk_valid;
    logic         tk_ready = 1'b0;
    logic         tk_last;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    craft_tweakey_sequencer #(.ROUNDS(ROUNDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .key(key), .tweak(tweak),
        .tk(tk), .tk_round(tk_round), .tk_valid(tk_valid), .tk_ready(tk_ready),
        .tk_last(tk_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] mix_ref(input logic [63:0] x);
        logic [3:0] n [16];
        logic [63:0] y;
        for (int i = 0; i < 16; i++) n[i] = x[63-4*i -: 4];
        for (int c = 0; c < 4; c++) begin
            n[c]     = n[c] ^ n[8+c] ^ n[12+c];
            n[4+c]   = n[4+c] ^ n[12+c];
        end
        y = '0;
        for (int i = 0; i < 16; i++) y[63-4*i -: 4] = n[i];
        return y;
    endfunction

    function automatic logic [63:0] exp_tk(input logic [127:0] k, input logic [63:0] t, input int r);
        int q [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};
        logic [3:0] tn [16];
        logic [63:0] kk, y;
        for (int i = 0; i < 16; i++) tn[i] = t[63-4*i -: 4];
        kk = (r % 2 == 0) ? k[127:64] : k[63:0];
        y = '0;
        for (int i = 0; i < 16; i++)
            y[63-4*i -: 4] = kk[63-4*i -: 4] ^ ((r % 4 < 2) ? tn[i] : tn[q[i]]);
`ifdef CRAFT_TK_MIXCOL_EN
        y = mix_ref(y);
`endif
        return y;
    endfunction

    // Raw literal tweakeys become their MixColumn image when the option is built in.
    function automatic logic [63:0] spec_tk(input logic [63:0] raw);
`ifdef CRAFT_TK_MIXCOL_EN
        return mix_ref(raw);
`else
        return raw;
`endif
    endfunction

    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_dir  = 1'b0;
    logic [127:0] m_key  = '0;
    logic [63:0]  m_tw   = '0;
    int           m_idx  = 0;

    // Compare process: checks the current cycle, then predicts the next from the sampled inputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_tk_valid", 64'(tk_valid), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_tk", tk, 64'd0);
            m_busy = 1'b0;
            m_done = 1'b0;
        end else begin
            int r;
            check("tk_valid", 64'(tk_valid), 64'(m_busy));
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            if (m_busy) begin
                r = m_dir ? ROUNDS - 1 - m_idx : m_idx;
                check("tk", tk, exp_tk(m_key, m_tw, r));
                check("tk_round", 64'(tk_round), 64'(r));
                check("tk_last", 64'(tk_last), 64'(m_idx == ROUNDS - 1));
            end
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1;
                    m_dir  = dir;
                    m_key  = key;
                    m_tw   = tweak;
                    m_idx  = 0;
                end
            end else if (tk_ready) begin
                if (m_idx == ROUNDS - 1) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic d);
        start = 1'b1;
        dir   = d;
        key   = KEY;
        tweak = TW;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int cnt;

        check("model_asc_r0", exp_tk(KEY, TW, 0), spec_tk(64'h01326754CDFEAB98));
        check("model_dec_r31", exp_tk(KEY, TW, 31), spec_tk(64'h426C42297FA98EE2));
`ifdef CRAFT_TK_MIXCOL_EN
        check("model_mix_r0", exp_tk(KEY, TW, 0), 64'h6754CCCCCDFEAB98);
`endif

        tick();
        tick();
        check("reset_tk_round", 64'(tk_round), 64'd0);
        check("reset_tk_last", 64'(tk_last), 64'd0);
        rst_n = 1'b1;
        tick();

        // Ascending run at full throughput.
        tk_ready = 1'b1;
        start_run(1'b0);
        check("asc_first_valid", 64'(tk_valid), 64'd1);
        check("asc_tk_r0", tk, spec_tk(64'h01326754CDFEAB98));
        check("asc_round_r0", 64'(tk_round), 64'd0);
        tick();
        check("asc_tk_r1", tk, spec_tk(64'h89BAEFDC45762310));
        cnt = 1;
        while (tk_valid && cnt < 100) begin
            if (tk_last) check("asc_last_round", 64'(tk_round), 64'd31);
            cnt++;
            tick();
        end
        check("asc_valid_cycles", 64'(cnt), 64'd32);
        check("asc_done", 64'(done), 64'd1);

        // Descending run launched on the done cycle, with backpressure and an ignored start.
        start_run(1'b1);
        check("dec_first_valid", 64'(tk_valid), 64'd1);
        check("dec_tk_r31", tk, spec_tk(64'h426C42297FA98EE2));
        check("dec_round_r31", 64'(tk_round), 64'd31);
        check("dec_last_r31", 64'(tk_last), 64'd0);
        tick();
        check("dec_tk_r30", tk, spec_tk(64'hCAE4CAA1F721066A));
        tk_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                start = 1'b1;
                dir   = 1'b0;
                key   = ~KEY;
                tweak = ~TW;
            end
            tick();
            start = 1'b0;
            dir   = 1'b1;
            key   = KEY;
            tweak = TW;
            check("bp_hold_tk", tk, spec_tk(64'hCAE4CAA1F721066A));
            check("bp_hold_round", 64'(tk_round), 64'd30);
        end
        tk_ready = 1'b1;
        tick();
        check("bp_release_round", 64'(tk_round), 64'd29);
        cnt = 0;
        while (!tk_last && cnt < 40) begin
            cnt++;
            tick();
        end
        check("dec_last_seen", 64'(tk_last), 64'd1);
        check("dec_last_round", 64'(tk_round), 64'd0);
        check("dec_last_tk", tk, spec_tk(64'h01326754CDFEAB98));
        tick();
        check("dec_done", 64'(done), 64'd1);
        start_run(1'b0);
        check("b2b_valid", 64'(tk_valid), 64'd1);
        check("b2b_round", 64'(tk_round), 64'd0);

        // Asynchronous reset mid-run.
        cnt = 0;
        while (tk_round != 8'd10 && cnt < 40) begin
            cnt++;
            tick();
        end
        check("reach_r10", 64'(tk_round), 64'd10);
        #2 rst_n = 1'b0;
        #1;
        check("abort_tk", tk, 64'd0);
        check("abort_round", 64'(tk_round), 64'd0);
        check("abort_valid", 64'(tk_valid), 64'd0);
        check("abort_last", 64'(tk_last), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_done", 64'(done), 64'd0);
        start_run(1'b1);
        check("restart_round", 64'(tk_round), 64'd31);
        check("restart_tk", tk, spec_tk(64'h426C42297FA98EE2));

        // Randomized traffic: random ready, random start pulses with fresh key/tweak/dir.
        for (int i = 0; i < 3000; i++) begin
            tk_ready = ($urandom_range(0, 3) != 0);
            start    = ($urandom_range(0, 5) == 0);
            dir      = 1'($urandom_range(0, 1));
            key      = {$urandom, $urandom, $urandom, $urandom};
            tweak    = {$urandom, $urandom};
            tick();
        end

        start    = 1'b0;
        tk_ready = 1'b1;
        for (int i = 0; i < 80; i++) tick();
        check("drain_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
